// File: rtl/multi_stair_renderer.sv
// Draws NUM_STAIRS rectangles into a VGA plot port one pixel per clock and
// scrolls them up one row per step, erasing the old image before redrawing.
// Ports: clock, reset_n (async, active-low); go/stop control levels;
// x_init/y_init packed per-stair origins; plot/x/y/colour pixel write;
// busy (state != IDLE); step_done (one-cycle pulse in MOVE).
module multi_stair_renderer #(
  parameter int          NUM_STAIRS      = 2,
  parameter int          STAIR_W         = 40,
  parameter int          STAIR_H         = 5,
  parameter int          FRAME_DIV       = 833334,
  parameter int          FRAMES_PER_STEP = 15,
  parameter logic [6:0]  Y_WRAP          = 7'd116,
  parameter logic [2:0]  FG_COLOUR       = 3'b100,
  parameter logic [2:0]  BG_COLOUR       = 3'b000
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    go,
  input  logic                    stop,
  input  logic [8*NUM_STAIRS-1:0] x_init,
  input  logic [7*NUM_STAIRS-1:0] y_init,
  output logic                    plot,
  output logic [7:0]              x,
  output logic [6:0]              y,
  output logic [2:0]              colour,
  output logic                    busy,
  output logic                    step_done
);

  localparam int IW = (NUM_STAIRS > 1) ? $clog2(NUM_STAIRS) : 1;
  localparam int RW = (STAIR_H > 1) ? $clog2(STAIR_H) : 1;
  localparam int CW = (STAIR_W > 1) ? $clog2(STAIR_W) : 1;

  localparam logic [IW-1:0] LAST_I = IW'(NUM_STAIRS - 1);
  localparam logic [RW-1:0] LAST_R = RW'(STAIR_H - 1);
  localparam logic [CW-1:0] LAST_C = CW'(STAIR_W - 1);
  localparam logic [31:0]   WAIT_CYC = 32'(FRAME_DIV * FRAMES_PER_STEP);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAW,
    S_WAIT,
    S_ERASE,
    S_MOVE
  } state_t;

  state_t        r_state;
  logic [6:0]    r_ypos [NUM_STAIRS];
  logic [IW-1:0] r_i;
  logic [RW-1:0] r_r;
  logic [CW-1:0] r_c;
  logic [31:0]   r_wcnt;
  logic          r_exit;

  logic [7:0]    w_xi  [NUM_STAIRS];
  logic [6:0]    w_yi  [NUM_STAIRS];
  logic [6:0]    w_ymv [NUM_STAIRS];
  logic [IW-1:0] w_ni;
  logic [RW-1:0] w_nr;
  logic [CW-1:0] w_nc;
  logic          w_last;

  always_comb begin
    for (int k = 0; k < NUM_STAIRS; k++) begin
      w_xi[k]  = x_init[8*k +: 8];
      w_yi[k]  = y_init[7*k +: 7];
      w_ymv[k] = (r_ypos[k] == 7'd0) ? Y_WRAP : r_ypos[k] - 7'd1;
    end
  end

  // Counters name the pixel currently on the output; w_n* is the one
  // that will be registered at the next edge (column fastest).
  always_comb begin
    w_last = (r_i == LAST_I) && (r_r == LAST_R) && (r_c == LAST_C);
    w_ni   = r_i;
    w_nr   = r_r;
    w_nc   = r_c + CW'(1);
    if (r_c == LAST_C) begin
      w_nc = '0;
      w_nr = r_r + RW'(1);
      if (r_r == LAST_R) begin
        w_nr = '0;
        w_ni = r_i + IW'(1);
      end
    end
  end

  assign busy = (r_state != S_IDLE);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      plot      <= 1'b0;
      x         <= '0;
      y         <= '0;
      colour    <= BG_COLOUR;
      step_done <= 1'b0;
      r_i       <= '0;
      r_r       <= '0;
      r_c       <= '0;
      r_wcnt    <= '0;
      r_exit    <= 1'b0;
      for (int k = 0; k < NUM_STAIRS; k++)
        r_ypos[k] <= '0;
    end else begin
      step_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          plot <= 1'b0;
          if (go)
            r_state <= S_LOAD;
        end
        S_LOAD: begin
          for (int k = 0; k < NUM_STAIRS; k++)
            r_ypos[k] <= w_yi[k];
          r_i     <= '0;
          r_r     <= '0;
          r_c     <= '0;
          plot    <= 1'b1;
          colour  <= FG_COLOUR;
          x       <= w_xi[0];
          y       <= w_yi[0];
          r_state <= S_DRAW;
        end
        S_DRAW, S_ERASE: begin
          if (w_last) begin
            plot   <= 1'b0;
            r_i    <= '0;
            r_r    <= '0;
            r_c    <= '0;
            r_wcnt <= '0;
            if (r_state == S_DRAW) begin
              r_state <= S_WAIT;
            end else if (r_exit) begin
              r_exit  <= 1'b0;
              r_state <= S_IDLE;
            end else begin
              step_done <= 1'b1;
              r_state   <= S_MOVE;
            end
          end else begin
            r_i <= w_ni;
            r_r <= w_nr;
            r_c <= w_nc;
            x   <= w_xi[w_ni] + 8'(w_nc);
            y   <= r_ypos[w_ni] + 7'(w_nr);
          end
        end
        S_WAIT: begin
          plot <= 1'b0;
          if (r_wcnt == WAIT_CYC - 32'd1) begin
            r_wcnt  <= '0;
            r_exit  <= stop;
            plot    <= 1'b1;
            colour  <= BG_COLOUR;
            x       <= w_xi[0];
            y       <= r_ypos[0];
            r_state <= S_ERASE;
          end else begin
            r_wcnt <= r_wcnt + 32'd1;
          end
        end
        S_MOVE: begin
          for (int k = 0; k < NUM_STAIRS; k++)
            r_ypos[k] <= w_ymv[k];
          plot    <= 1'b1;
          colour  <= FG_COLOUR;
          x       <= w_xi[0];
          y       <= w_ymv[0];
          r_state <= S_DRAW;
        end
        default: begin
          plot    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multi_stair_renderer.sv
// Bench for multi_stair_renderer: spec-level pixel model checked every
// cycle, plus directed literal expectations from the test plan.
module tb_multi_stair_renderer;

  localparam int NS = 2;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int FD = 3;
  localparam int FP = 2;
  localparam int YW = 116;
  localparam int NP = NS * W * H;
  localparam int WC = FD * FP;

  logic          clock = 1'b0;
  logic          reset_n;
  logic          go;
  logic          stop;
  logic [15:0]   x_init;
  logic [13:0]   y_init;
  logic          plot;
  logic [7:0]    x;
  logic [6:0]    y;
  logic [2:0]    colour;
  logic          busy;
  logic          step_done;

  multi_stair_renderer #(
    .NUM_STAIRS(NS),
    .STAIR_W(W),
    .STAIR_H(H),
    .FRAME_DIV(FD),
    .FRAMES_PER_STEP(FP),
    .Y_WRAP(7'd116),
    .FG_COLOUR(3'b100),
    .BG_COLOUR(3'b000)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .go(go),
    .stop(stop),
    .x_init(x_init),
    .y_init(y_init),
    .plot(plot),
    .x(x),
    .y(y),
    .colour(colour),
    .busy(busy),
    .step_done(step_done)
  );

  initial forever #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // model: phase 0 idle,1 load,2 draw,3 wait,4 erase,5 move
  int m_ph = 0;
  int m_k  = 0;
  int m_ex = 0;
  int m_yp [NS];

  task automatic model_reset();
    m_ph = 0;
    m_k  = 0;
    m_ex = 0;
    for (int i = 0; i < NS; i++) m_yp[i] = 0;
  endtask

  task automatic model_step(input logic g, input logic s, input logic rn);
    if (!rn) begin
      model_reset();
    end else begin
      case (m_ph)
        0: if (g) m_ph = 1;
        1: begin
          for (int i = 0; i < NS; i++)
            m_yp[i] = int'((y_init >> (7 * i)) & 14'h7F);
          m_ph = 2;
          m_k  = 0;
        end
        2: if (m_k == NP - 1) begin m_ph = 3; m_k = 0; end
           else m_k++;
        3: if (m_k == WC - 1) begin m_ph = 4; m_k = 0; m_ex = int'(s); end
           else m_k++;
        4: if (m_k == NP - 1) begin
             m_k  = 0;
             m_ph = m_ex ? 0 : 5;
             m_ex = 0;
           end else m_k++;
        5: begin
          for (int i = 0; i < NS; i++)
            m_yp[i] = (m_yp[i] == 0) ? YW : m_yp[i] - 1;
          m_ph = 2;
          m_k  = 0;
        end
        default: m_ph = 0;
      endcase
    end
  endtask

  task automatic model_compare();
    logic       ep, eb, es;
    logic [7:0] ex;
    logic [6:0] ey;
    logic [2:0] ec;
    int         si, sr, sc;
    logic       bad;
    ep = (m_ph == 2) || (m_ph == 4);
    eb = (m_ph != 0);
    es = (m_ph == 5);
    si = m_k / (W * H);
    sr = (m_k / W) % H;
    sc = m_k % W;
    ex = 8'((int'((x_init >> (8 * si)) & 16'hFF) + sc) % 256);
    ey = 7'((m_yp[si] + sr) % 128);
    ec = (m_ph == 2) ? 3'b100 : 3'b000;
    bad = (plot !== ep) || (busy !== eb) || (step_done !== es);
    if (ep && ((x !== ex) || (y !== ey) || (colour !== ec))) bad = 1'b1;
    n_tests++;
    if (bad) begin
      n_fail++;
      $display("FAIL model cyc%0d: got p=%b x=%0d y=%0d c=%0d b=%b s=%b want p=%b x=%0d y=%0d c=%0d b=%b s=%b",
               cyc, plot, x, y, colour, busy, step_done,
               ep, ex, ey, ec, eb, es);
    end
  endtask

  task automatic tick();
    logic g, s, rn;
    @(posedge clock);
    g  = go;
    s  = stop;
    rn = reset_n;
    @(negedge clock);
    cyc++;
    model_step(g, s, rn);
    model_compare();
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_px(input string nm, input int ex, input int ey,
                        input int ec);
    logic [18:0] a, e;
    a = {plot, x, y, colour};
    e = {1'b1, 8'(ex), 7'(ey), 3'(ec)};
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got p=%b x=%0d y=%0d c=%0d want p=1 x=%0d y=%0d c=%0d",
               nm, plot, x, y, colour, ex, ey, ec);
    end
  endtask

  initial begin
    int plots, bcnt, sds, found;
    reset_n = 1'b0;
    go      = 1'b0;
    stop    = 1'b0;
    x_init  = {8'd20, 8'd10};
    y_init  = {7'd50, 7'd30};
    model_reset();

    repeat (3) tick();
    chk("rst_plot", 32'(plot), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_col", 32'(colour), 0);
    reset_n = 1'b1;
    repeat (3) tick();
    chk("idle_busy", 32'(busy), 0);
    chk("idle_xy", {x, y}, 0);
    chk("idle_sd", 32'(step_done), 0);

    // first sweep
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("load_busy", 32'(busy), 1);
    chk("load_plot", 32'(plot), 0);
    for (int p = 0; p < NP; p++) begin
      tick();
      if (p < 4) chk_px("draw0_s0", 10 + p, 30, 4);
      if (p >= 8 && p < 12) chk_px("draw0_s1", 20 + p - 8, 50, 4);
      if (p == 15) chk_px("draw0_last", 23, 51, 4);
    end
    for (int k = 0; k < WC; k++) begin
      tick();
      chk("wait_plot", 32'(plot), 0);
    end
    for (int p = 0; p < NP; p++) begin
      tick();
      if (p == 0) chk_px("erase_first", 10, 30, 0);
      if (p == 8) chk_px("erase_s1", 20, 50, 0);
      if (p == 15) chk_px("erase_last", 23, 51, 0);
    end
    tick();
    chk("move_sd", 32'(step_done), 1);
    chk("move_plot", 32'(plot), 0);
    tick();
    chk_px("draw1_s0", 10, 29, 4);
    repeat (8) tick();
    chk_px("draw1_s1", 20, 49, 4);

    // stop during DRAW only must not end the run
    stop = 1'b1;
    repeat (3) tick();
    stop = 1'b0;
    found = 0;
    for (int k = 0; k < 60 && found == 0; k++) begin
      tick();
      if (step_done) found = 1;
    end
    chk("stop_in_draw_ignored", 32'(found), 1);

    // stop sampled in the final WAIT cycle
    repeat (NP + WC) tick();
    chk("last_wait_plot", 32'(plot), 0);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    plots = 0;
    bcnt  = 0;
    sds   = 0;
    found = 0;
    for (int k = 0; k < 40; k++) begin
      if (!busy) begin
        found = 1;
        break;
      end
      plots += int'(plot);
      sds   += int'(step_done);
      bcnt++;
      tick();
    end
    chk("stop_idle_reached", 32'(found), 1);
    chk("stop_erase_len", 32'(plots), 16);
    chk("stop_busy_len", 32'(bcnt), 16);
    chk("stop_no_sd", 32'(sds), 0);

    // asynchronous reset mid-DRAW
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (5) tick();
    #2 reset_n = 1'b0;
    #1;
    chk("arst_plot", 32'(plot), 0);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_xy", {x, y}, 0);
    model_reset();
    repeat (2) tick();
    reset_n = 1'b1;
    repeat (2) tick();
    chk("arst_idle", 32'(busy), 0);

    // wrap and x truncation
    x_init = {8'd254, 8'd10};
    y_init = {7'd50, 7'd0};
    go = 1'b1;
    tick();
    go = 1'b0;
    tick();
    chk_px("wrap_d0", 10, 0, 4);
    repeat (8) tick();
    chk_px("trunc0", 254, 50, 4);
    tick();
    chk_px("trunc1", 255, 50, 4);
    tick();
    chk_px("trunc2", 0, 50, 4);
    tick();
    chk_px("trunc3", 1, 50, 4);
    repeat (4 + WC + NP + 1) tick();
    chk("wrap_move_sd", 32'(step_done), 1);
    tick();
    chk_px("wrap_row0", 10, 116, 4);
    repeat (4) tick();
    chk_px("wrap_row1", 10, 117, 4);

    // go held high through return to IDLE restarts via LOAD
    go   = 1'b1;
    stop = 1'b1;
    found = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (!busy) begin
        found = 1;
        break;
      end
    end
    chk("restart_idle", 32'(found), 1);
    tick();
    go   = 1'b0;
    stop = 1'b0;
    chk("restart_load", {31'd0, busy}, 1);
    tick();
    chk_px("restart_px0", 10, 0, 4);
    repeat (40) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multi_stair_renderer.md
# multi_stair_renderer

Parametrised renderer that draws NUM_STAIRS solid rectangles ("stairs") into the VGA pixel-write port, one pixel per clock, and scrolls them upward by one row every FRAMES_PER_STEP frames with erase-before-redraw. Sits between the game control logic, which supplies start positions and go/stop, and the VGA adapter's plot/x/y/colour inputs. It generalises the single-stair draw/wait/erase/move datapath in three ways: multiple stairs, configurable geometry and timing, and a clean stop path.

## Interface
- NUM_STAIRS, 2, number of stairs rendered per sweep (1..8)
- STAIR_W, 40, stair width in pixels (1..160)
- STAIR_H, 5, stair height in pixels (1..120)
- FRAME_DIV, 833334, clock cycles per frame tick (≥1)
- FRAMES_PER_STEP, 15, frame ticks between scroll steps (≥1)
- Y_WRAP, 116, y value loaded when a stair at y=0 moves up
- FG_COLOUR, 3'b100, draw colour
- BG_COLOUR, 3'b000, erase colour
- clock  in  1  system clock, all logic on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- go  in  1  level; sampled in IDLE, starts animation
- stop  in  1  level; sampled in WAIT, ends animation after erase
- x_init  in  8*NUM_STAIRS  stair i left x at bits [8i+7:8i]
- y_init  in  7*NUM_STAIRS  stair i top y at bits [7i+6:7i], latched in LOAD
- plot  out  1  pixel write strobe
- x  out  8  pixel x
- y  out  7  pixel y
- colour  out  3  pixel colour
- busy  out  1  high whenever state ≠ IDLE
- step_done  out  1  one-cycle pulse in MOVE

## Operation
- States: IDLE, LOAD, DRAW, WAIT, ERASE, MOVE.
- IDLE: go=1 → LOAD; otherwise stay.
- LOAD (1 cycle): ypos[i] ← y_init[i] for all i; → DRAW.
- DRAW: sweep all pixels with colour=FG_COLOUR, plot=1; after the last pixel → WAIT.
- WAIT: count FRAME_DIV*FRAMES_PER_STEP cycles. When the count completes: stop=1 → ERASE with an exit flag set; stop=0 → ERASE.
- ERASE: same sweep with colour=BG_COLOUR, plot=1. After the last pixel: exit flag set → IDLE (flag cleared); otherwise → MOVE.
- MOVE (1 cycle): for each i, ypos[i] ← (ypos[i]==0) ? Y_WRAP : ypos[i]−1; step_done=1; → DRAW.
- Sweep order: stair index 0..NUM_STAIRS−1; within a stair, rows r=0..STAIR_H−1; within a row, columns c=0..STAIR_W−1 (c fastest).
- Pixel address: x = x_init[i] + c mod 256; y = ypos[i] + r mod 128. No clipping; truncation is the defined behaviour.
- x_init is used live, not latched, so a change takes effect at the next pixel.
- Sweep counters (i, r, c) reset to 0 on entry to DRAW and on entry to ERASE.
- Overlapping stairs: later index wins in DRAW; erase may clear pixels shared with other stairs, which is acceptable.

## Timing
- Reset (asynchronous, immediate, mid-operation included): state=IDLE, plot=0, x=0, y=0, colour=BG_COLOUR, busy=0, step_done=0, ypos=0, all counters=0, exit flag=0.
- x, y, colour and plot are registered and valid together. The first DRAW pixel appears in the cycle after LOAD.
- go high at edge t → LOAD during t+1 → first plot during t+2.
- DRAW and ERASE each last exactly NUM_STAIRS*STAIR_W*STAIR_H cycles with plot=1 continuously.
- WAIT lasts exactly FRAME_DIV*FRAMES_PER_STEP cycles with plot=0.
- MOVE lasts 1 cycle; step period = 2·N·W·H + FRAME_DIV·FRAMES_PER_STEP + 1 cycles.
- stop is ignored outside WAIT and sampled only in the final WAIT cycle. go is ignored outside IDLE.
- go held high through the return to IDLE restarts immediately via LOAD.

## Test plan
Common parameters: NUM_STAIRS=2, STAIR_W=4, STAIR_H=2, FRAME_DIV=3, FRAMES_PER_STEP=2, Y_WRAP=116; x_init={8'd20, 8'd10}, y_init={7'd50, 7'd30}.
- Reset check: assert reset_n=0 mid-DRAW → same cycle plot=0, busy=0. Release with go=0 → stays IDLE, outputs at their reset values.
- First sweep: pulse go → 16 consecutive plots with colour=3'b100. Pixels 0..3 are (10..13, 30), pixels 8..11 are (20..23, 50), the last is (23, 51). Then plot=0 for exactly 6 cycles.
- Erase and move: following WAIT → 16 plots with colour=3'b000 at identical coordinates, then step_done for 1 cycle, then a DRAW with y starting at 29 and 49.
- Wrap: y_init stair0=0 → after the first MOVE, stair0 draws rows 116..117.
- Truncation: x_init stair1=254 → x sequence 254, 255, 0, 1.
- Stop: stop=1 during the last WAIT cycle → ERASE of 16 pixels, no step_done, busy falls the cycle after the last erase pixel. stop=1 during DRAW only → no effect.
